sdram_init_ref: RTL and testbench
=================================

Name: sdram_init_ref

Overview:
- Parametrised successor to the fixed SDRAM power-up sequencer.
- Performs the JEDEC init sequence: wait, PRECHARGE-all, N×AUTO-REFRESH, MODE REGISTER SET. The mode register value is built from parameters.
- Then runs a periodic auto-refresh engine with a req/en/done handshake toward the future read/write arbiter.
- Sits under the sdram top; drives the command bus {CS_N,RAS_N,CAS_N,WE_N}, address and bank lines.

Parameters:
- CLK_FREQ_MHZ, 50, clock frequency used to convert the wait time to cycles.
- INIT_WAIT_US, 200, power-up wait in µs. Wait cycles W = INIT_WAIT_US*CLK_FREQ_MHZ.
- ADDR_W, 13, SDRAM address width (≥11).
- BA_W, 2, bank address width.
- TRP_CYC, 2, PRECHARGE-to-next-command spacing, in cycles (≥1).
- TRFC_CYC, 7, AUTO-REFRESH-to-next-command spacing, in cycles (≥1).
- TMRD_CYC, 2, MRS-to-init-end spacing, in cycles (≥1).
- INIT_REF_NUM, 8, number of AUTO-REFRESH commands during init (≥1).
- CAS_LAT, 3, CAS latency field, mode register A[6:4].
- BURST_CODE, 3, burst length code, A[2:0].
- WB_SINGLE, 0, write-burst mode bit, A9.
- REF_INTERVAL_CYC, 390, cycles between refresh requests (7.8 µs at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd  out  4  {CS_N,RAS_N,CAS_N,WE_N}. NOP=0111, PRE=0010, AREF=0001, MRS=0000.
- addr  out  ADDR_W  SDRAM address.
- ba  out  BA_W  bank address; always 0.
- flag_init_end  out  1  high once init is complete; stays high until reset.
- ref_req  out  1  refresh request to arbiter.
- ref_en  in  1  arbiter grant for refresh.
- ref_done  out  1  one-cycle pulse when the refresh sequence completes.
- ref_overrun  out  1  sticky; a refresh interval expired while a request was still pending.

Behaviour:
- Reset (rst_n low at a clk edge): cmd=0111, addr=0, ba=0, flag_init_end=0, ref_req=0, ref_done=0, ref_overrun=0. FSM goes to S_WAIT and all counters clear.
- Reset asserted mid-operation (init or refresh) aborts immediately and restarts the full init after release.
- Command discipline:
  - Every non-NOP command is driven for exactly one cycle; NOP in all other cycles.
  - The spacing T between commands means the next command appears T cycles after the previous one.
- addr values:
  - PRE: addr[10]=1, all other bits 0.
  - AREF and NOP: addr=0.
  - MRS: addr = {zeros, WB_SINGLE, 2'b00, CAS_LAT[2:0], 1'b0 (sequential), BURST_CODE[2:0]}.
- FSM states: S_WAIT → S_PRE → S_TRP → S_AREF → S_TRFC → (loop to S_AREF until INIT_REF_NUM issued) → S_MRS → S_TMRD → S_IDLE → (S_RPRE → S_RTRP → S_RAREF → S_RTRFC → S_IDLE).
- Init timing (cycle 0 = first edge with rst_n high):
  - PRE at cycle W.
  - k-th AREF (k=0..N-1) at W+TRP_CYC+k*TRFC_CYC.
  - MRS at W+TRP_CYC+N*TRFC_CYC.
  - flag_init_end rises at MRS+TMRD_CYC.
- Refresh interval counter:
  - Starts from 0 in the cycle flag_init_end rises and runs free.
  - Wraps every REF_INTERVAL_CYC cycles; each wrap sets ref_req, first at flag-rise + REF_INTERVAL_CYC.
  - If a wrap occurs while ref_req is already high, ref_overrun is set and stays set until reset.
- Handshake:
  - ref_en is honoured only when sampled high together with ref_req in S_IDLE; ref_en in any other case is ignored.
  - PRE is issued the next cycle and ref_req clears in that same cycle.
  - AREF follows TRP_CYC after PRE.
  - ref_done pulses TRFC_CYC after AREF; FSM returns to S_IDLE in the same cycle.
- A wrap during a refresh sequence (ref_req already cleared) sets ref_req normally, not overrun.
- A wrap coinciding with the ref_req clear cycle: the set wins, ref_req stays high, and no overrun is flagged.
- No request is generated and no handshake is accepted before flag_init_end.

Test Plan:
- Init, INIT_WAIT_US=1 (W=50), other params default -> PRE at cycle 50 with addr=0x0400; AREF at 52, 59, …, 101; MRS at 108 with addr=0x0033; flag_init_end high from 110; NOP on cmd in every other cycle.
- Refresh with ref_en tied high, REF_INTERVAL_CYC=20 -> ref_req at 130; PRE at 131 with ref_req low; AREF at 133; ref_done pulse at 140; next ref_req at 150.
- Refresh with ref_en held low, REF_INTERVAL_CYC=20 -> ref_req high at 130; ref_overrun sets at 150; grant at 160 -> PRE at 161, sequence completes, ref_overrun remains 1.
- rst_n low for 1 cycle during the 4th init AREF -> all outputs return to reset values; init restarts; PRE exactly W cycles after release.
- Parameter sweep CAS_LAT=2, BURST_CODE=0, WB_SINGLE=1, INIT_REF_NUM=2 -> MRS addr=0x0220; exactly 2 init AREFs.
- ref_en pulsed while ref_req low, and ref_en pulsed during S_RTRFC -> no extra command issued; no ref_done.

Source files
------------

// File: rtl/sdram_init_ref.sv
// SDRAM power-up sequencer (wait, PRECHARGE-all, N x AUTO-REFRESH, MRS)
// followed by a periodic auto-refresh engine with a req/en/done handshake.
module sdram_init_ref #(
  parameter int unsigned CLK_FREQ_MHZ     = 50,
  parameter int unsigned INIT_WAIT_US     = 200,
  parameter int unsigned ADDR_W           = 13,
  parameter int unsigned BA_W             = 2,
  parameter int unsigned TRP_CYC          = 2,
  parameter int unsigned TRFC_CYC         = 7,
  parameter int unsigned TMRD_CYC         = 2,
  parameter int unsigned INIT_REF_NUM     = 8,
  parameter int unsigned CAS_LAT          = 3,
  parameter int unsigned BURST_CODE       = 3,
  parameter int unsigned WB_SINGLE        = 0,
  parameter int unsigned REF_INTERVAL_CYC = 390
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [3:0]        o_cmd,
  output logic [ADDR_W-1:0] o_addr,
  output logic [BA_W-1:0]   o_ba,
  output logic              o_flag_init_end,
  output logic              o_ref_req,
  input  logic              i_ref_en,
  output logic              o_ref_done,
  output logic              o_ref_overrun
);

  localparam int unsigned WAIT_CYC = INIT_WAIT_US * CLK_FREQ_MHZ;
  localparam int unsigned MAX_A    = (WAIT_CYC > TRFC_CYC) ? WAIT_CYC : TRFC_CYC;
  localparam int unsigned MAX_B    = (TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC;
  localparam int unsigned MAX_T    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = $clog2(MAX_T + 1);
  localparam int unsigned RI_W     = $clog2(REF_INTERVAL_CYC + 1);
  localparam int unsigned REFN_W   = $clog2(INIT_REF_NUM + 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam logic [9:0] MODE_BITS = {1'(WB_SINGLE), 2'b00, 3'(CAS_LAT), 1'b0, 3'(BURST_CODE)};
  localparam logic [ADDR_W-1:0] MRS_VAL  = ADDR_W'(MODE_BITS);
  localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(11'h400);

  typedef enum logic [3:0] {
    S_WAIT, S_PRE, S_TRP, S_AREF, S_TRFC, S_MRS, S_TMRD,
    S_IDLE, S_RPRE, S_RTRP, S_RAREF, S_RTRFC
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [REFN_W-1:0]   r_aref_cnt;
  logic [RI_W-1:0]     r_icnt;
  logic [3:0]          r_cmd, w_cmd_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_flag, r_ref_req, r_done, r_ovr;
  logic                w_cnt_clr, w_aref_inc, w_init_done, w_grant, w_done, w_wrap;

  // Next-state, spacing-counter control and the command to register
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_aref_inc  = 1'b0;
    w_init_done = 1'b0;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_cmd_nxt   = CMD_NOP;
    w_addr_nxt  = '0;
    w_wrap      = r_flag && (r_icnt == RI_W'(REF_INTERVAL_CYC - 1));
    case (r_state)
      S_WAIT: if (r_cnt == CNT_W'(WAIT_CYC)) begin
        w_state_nxt = S_PRE;
        w_cnt_clr   = 1'b1;
      end
      S_PRE, S_TRP: if (r_cnt == CNT_W'(TRP_CYC - 1)) begin
        w_state_nxt = S_AREF;
        w_cnt_clr   = 1'b1;
        w_aref_inc  = 1'b1;
      end else begin
        w_state_nxt = S_TRP;
      end
      S_AREF, S_TRFC: if (r_cnt == CNT_W'(TRFC_CYC - 1)) begin
        w_cnt_clr = 1'b1;
        if (r_aref_cnt == REFN_W'(INIT_REF_NUM)) begin
          w_state_nxt = S_MRS;
        end else begin
          w_state_nxt = S_AREF;
          w_aref_inc  = 1'b1;
        end
      end else begin
        w_state_nxt = S_TRFC;
      end
      S_MRS, S_TMRD: if (r_cnt == CNT_W'(TMRD_CYC - 1)) begin
        w_state_nxt = S_IDLE;
        w_init_done = 1'b1;
      end else begin
        w_state_nxt = S_TMRD;
      end
      S_IDLE: if (r_ref_req && i_ref_en) begin
        w_state_nxt = S_RPRE;
        w_cnt_clr   = 1'b1;
        w_grant     = 1'b1;
      end
      S_RPRE, S_RTRP: if (r_cnt == CNT_W'(TRP_CYC - 1)) begin
        w_state_nxt = S_RAREF;
        w_cnt_clr   = 1'b1;
      end else begin
        w_state_nxt = S_RTRP;
      end
      S_RAREF, S_RTRFC: if (r_cnt == CNT_W'(TRFC_CYC - 1)) begin
        w_state_nxt = S_IDLE;
        w_cnt_clr   = 1'b1;
        w_done      = 1'b1;
      end else begin
        w_state_nxt = S_RTRFC;
      end
      default: w_state_nxt = S_WAIT;
    endcase
    case (w_state_nxt)
      S_PRE, S_RPRE: begin
        w_cmd_nxt  = CMD_PRE;
        w_addr_nxt = PRE_ADDR;
      end
      S_AREF, S_RAREF: w_cmd_nxt = CMD_AREF;
      S_MRS: begin
        w_cmd_nxt  = CMD_MRS;
        w_addr_nxt = MRS_VAL;
      end
      default: w_cmd_nxt = CMD_NOP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_WAIT;
      r_cnt      <= '0;
      r_aref_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_aref_inc) begin
        r_aref_cnt <= r_aref_cnt + REFN_W'(1);
      end
    end
  end

  // Output registers and refresh-interval bookkeeping; a wrap beats a grant clear
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cmd     <= CMD_NOP;
      r_addr    <= '0;
      r_flag    <= 1'b0;
      r_ref_req <= 1'b0;
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
      r_icnt    <= '0;
    end else begin
      r_cmd  <= w_cmd_nxt;
      r_addr <= w_addr_nxt;
      r_done <= w_done;
      if (w_init_done) begin
        r_flag <= 1'b1;
      end
      if (!r_flag || w_wrap) begin
        r_icnt <= '0;
      end else begin
        r_icnt <= r_icnt + RI_W'(1);
      end
      if (w_wrap) begin
        r_ref_req <= 1'b1;
        if (r_ref_req && !w_grant) begin
          r_ovr <= 1'b1;
        end
      end else if (w_grant) begin
        r_ref_req <= 1'b0;
      end
    end
  end

  assign o_cmd           = r_cmd;
  assign o_addr          = r_addr;
  assign o_ba            = '0;
  assign o_flag_init_end = r_flag;
  assign o_ref_req       = r_ref_req;
  assign o_ref_done      = r_done;
  assign o_ref_overrun   = r_ovr;

endmodule

// File: tb/tb_sdram_init_ref.sv
// Scoreboard bench for sdram_init_ref: two instances (default-ish and a
// mode-register sweep), expected commands queued per scenario and popped by cycle.
module tb_sdram_init_ref;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;
  localparam int W = 50;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ref_en_a = 1'b0;
  logic ref_en_b = 1'b0;

  logic [3:0]  a_cmd, b_cmd;
  logic [12:0] a_addr, b_addr;
  logic [1:0]  a_ba, b_ba;
  logic        a_flag, a_req, a_done, a_ovr;
  logic        b_flag, b_req, b_done, b_ovr;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = -1;

  always #5 clk = ~clk;

  sdram_init_ref #(
    .INIT_WAIT_US(1), .REF_INTERVAL_CYC(20)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_cmd(a_cmd), .o_addr(a_addr), .o_ba(a_ba),
    .o_flag_init_end(a_flag), .o_ref_req(a_req), .i_ref_en(ref_en_a),
    .o_ref_done(a_done), .o_ref_overrun(a_ovr)
  );

  sdram_init_ref #(
    .INIT_WAIT_US(1), .CAS_LAT(2), .BURST_CODE(0), .WB_SINGLE(1), .INIT_REF_NUM(2)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .o_cmd(b_cmd), .o_addr(b_addr), .o_ba(b_ba),
    .o_flag_init_end(b_flag), .o_ref_req(b_req), .i_ref_en(ref_en_b),
    .o_ref_done(b_done), .o_ref_overrun(b_ovr)
  );

  task automatic push(input bit to_b, input int c, input logic [3:0] cmd, input logic [12:0] addr);
    exp_t e;
    e = '{c, cmd, addr};
    if (to_b) qb.push_back(e);
    else qa.push_back(e);
  endtask

  // Init sequence with TRP=2, TRFC=7 as derived from the timing formulas
  task automatic push_init(input bit to_b, input int n, input logic [12:0] mrs);
    push(to_b, W, PRE, 13'h400);
    for (int k = 0; k < n; k++) push(to_b, W + 2 + k * 7, AREF, 13'h0);
    push(to_b, W + 2 + n * 7, MRS, mrs);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    qa.delete();
    qb.delete();
  endtask

  // Advance one cycle and pop whatever each instance is expected to show now
  task automatic tick(output exp_t ea, output exp_t eb);
    @(negedge clk);
    cyc++;
    if (qa.size() != 0 && qa[0].cyc == cyc) ea = qa.pop_front();
    else ea = '{cyc, NOP, 13'h0};
    if (qb.size() != 0 && qb[0].cyc == cyc) eb = qb.pop_front();
    else eb = '{cyc, NOP, 13'h0};
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({a_cmd, a_addr, a_ba, a_flag, a_req, a_done, a_ovr} !== {NOP, 13'h0, 2'b00, 4'b0000}) begin
        n_err++;
        $display("FAIL reset_a i=%0d got cmd=%b addr=%h ba=%b st=%b", i, a_cmd, a_addr, a_ba,
                 {a_flag, a_req, a_done, a_ovr});
      end
      n_vec++;
      if ({b_cmd, b_addr, b_ba, b_flag, b_req, b_done, b_ovr} !== {NOP, 13'h0, 2'b00, 4'b0000}) begin
        n_err++;
        $display("FAIL reset_b i=%0d got cmd=%b addr=%h ba=%b st=%b", i, b_cmd, b_addr, b_ba,
                 {b_flag, b_req, b_done, b_ovr});
      end
    end
  endtask

  task automatic test_init();
    exp_t ea, eb;
    int   b_arefs;
    b_arefs = 0;
    ref_en_a = 1'b0;
    do_reset();
    push_init(1'b0, 8, 13'h033);
    push_init(1'b1, 2, 13'h220);
    for (int i = 0; i <= 115; i++) begin
      tick(ea, eb);
      n_vec++;
      if ({a_cmd, a_addr, a_ba} !== {ea.cmd, ea.addr, 2'b00}) begin
        n_err++;
        $display("FAIL init_cmd_a cyc=%0d got %b/%h exp %b/%h", cyc, a_cmd, a_addr, ea.cmd, ea.addr);
      end
      n_vec++;
      if ({b_cmd, b_addr, b_ba} !== {eb.cmd, eb.addr, 2'b00}) begin
        n_err++;
        $display("FAIL init_cmd_b cyc=%0d got %b/%h exp %b/%h", cyc, b_cmd, b_addr, eb.cmd, eb.addr);
      end
      if (b_cmd === AREF) b_arefs++;
      n_vec++;
      if ({a_flag, a_req, a_done, a_ovr, b_flag, b_req} !== {cyc >= 110, 3'b000, cyc >= 68, 1'b0}) begin
        n_err++;
        $display("FAIL init_status cyc=%0d got a=%b b=%b%b", cyc, {a_flag, a_req, a_done, a_ovr},
                 b_flag, b_req);
      end
    end
    n_vec++;
    if (b_arefs != 2 || qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL init_leftover got b_arefs=%0d qa=%0d qb=%0d exp 2/0/0", b_arefs, qa.size(), qb.size());
    end
  endtask

  task automatic test_refresh();
    exp_t ea, eb;
    logic [3:0] xs;
    ref_en_a = 1'b1;
    do_reset();
    push_init(1'b0, 8, 13'h033);
    push(1'b0, 131, PRE, 13'h400);
    push(1'b0, 133, AREF, 13'h0);
    push(1'b0, 151, PRE, 13'h400);
    push(1'b0, 153, AREF, 13'h0);
    for (int i = 0; i <= 158; i++) begin
      tick(ea, eb);
      n_vec++;
      if ({a_cmd, a_addr, a_ba} !== {ea.cmd, ea.addr, 2'b00}) begin
        n_err++;
        $display("FAIL refresh_cmd cyc=%0d got %b/%h exp %b/%h", cyc, a_cmd, a_addr, ea.cmd, ea.addr);
      end
      xs = {cyc >= 110, cyc == 130 || cyc == 150, cyc == 140, 1'b0};
      n_vec++;
      if ({a_flag, a_req, a_done, a_ovr} !== xs) begin
        n_err++;
        $display("FAIL refresh_status cyc=%0d got %b exp %b", cyc, {a_flag, a_req, a_done, a_ovr}, xs);
      end
    end
    n_vec++;
    if (qa.size() != 0) begin
      n_err++;
      $display("FAIL refresh_leftover got %0d pending exp 0", qa.size());
    end
    ref_en_a = 1'b0;
  endtask

  task automatic test_overrun();
    exp_t ea, eb;
    logic [3:0] xs;
    ref_en_a = 1'b0;
    do_reset();
    push_init(1'b0, 8, 13'h033);
    push(1'b0, 161, PRE, 13'h400);
    push(1'b0, 163, AREF, 13'h0);
    for (int i = 0; i <= 175; i++) begin
      tick(ea, eb);
      n_vec++;
      if ({a_cmd, a_addr, a_ba} !== {ea.cmd, ea.addr, 2'b00}) begin
        n_err++;
        $display("FAIL overrun_cmd cyc=%0d got %b/%h exp %b/%h", cyc, a_cmd, a_addr, ea.cmd, ea.addr);
      end
      xs = {cyc >= 110, (cyc >= 130 && cyc <= 160) || cyc >= 170, cyc == 170, cyc >= 150};
      n_vec++;
      if ({a_flag, a_req, a_done, a_ovr} !== xs) begin
        n_err++;
        $display("FAIL overrun_status cyc=%0d got %b exp %b", cyc, {a_flag, a_req, a_done, a_ovr}, xs);
      end
      ref_en_a = (cyc == 160);
    end
    n_vec++;
    if (qa.size() != 0) begin
      n_err++;
      $display("FAIL overrun_leftover got %0d pending exp 0", qa.size());
    end
  endtask

  task automatic test_reset_mid_init();
    exp_t ea, eb;
    ref_en_a = 1'b0;
    do_reset();
    push_init(1'b0, 8, 13'h033);
    for (int i = 0; i <= 73; i++) begin
      tick(ea, eb);
      n_vec++;
      if ({a_cmd, a_addr, a_flag} !== {ea.cmd, ea.addr, 1'b0}) begin
        n_err++;
        $display("FAIL midrst_pre cyc=%0d got %b/%h exp %b/%h", cyc, a_cmd, a_addr, ea.cmd, ea.addr);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_cmd, a_addr, a_ba, a_flag, a_req, a_done, a_ovr} !== {NOP, 13'h0, 2'b00, 4'b0000}) begin
      n_err++;
      $display("FAIL midrst_outputs got cmd=%b addr=%h st=%b exp cmd=0111 addr=0 st=0000", a_cmd, a_addr,
               {a_flag, a_req, a_done, a_ovr});
    end
    rst_n = 1'b1;
    cyc = -1;
    qa.delete();
    qb.delete();
    push(1'b0, W, PRE, 13'h400);
    push(1'b0, W + 2, AREF, 13'h0);
    for (int i = 0; i <= 55; i++) begin
      tick(ea, eb);
      n_vec++;
      if ({a_cmd, a_addr, a_flag} !== {ea.cmd, ea.addr, 1'b0}) begin
        n_err++;
        $display("FAIL midrst_restart cyc=%0d got %b/%h exp %b/%h", cyc, a_cmd, a_addr, ea.cmd, ea.addr);
      end
    end
    n_vec++;
    if (qa.size() != 0) begin
      n_err++;
      $display("FAIL midrst_leftover got %0d pending exp 0", qa.size());
    end
  endtask

  task automatic test_ignored_en();
    exp_t ea, eb;
    logic [3:0] xs;
    ref_en_a = 1'b0;
    do_reset();
    push_init(1'b0, 8, 13'h033);
    push(1'b0, 131, PRE, 13'h400);
    push(1'b0, 133, AREF, 13'h0);
    for (int i = 0; i <= 148; i++) begin
      tick(ea, eb);
      n_vec++;
      if ({a_cmd, a_addr, a_ba} !== {ea.cmd, ea.addr, 2'b00}) begin
        n_err++;
        $display("FAIL ignen_cmd cyc=%0d got %b/%h exp %b/%h", cyc, a_cmd, a_addr, ea.cmd, ea.addr);
      end
      xs = {cyc >= 110, cyc == 130, cyc == 140, 1'b0};
      n_vec++;
      if ({a_flag, a_req, a_done, a_ovr} !== xs) begin
        n_err++;
        $display("FAIL ignen_status cyc=%0d got %b exp %b", cyc, {a_flag, a_req, a_done, a_ovr}, xs);
      end
      ref_en_a = (cyc == 60 || cyc == 115 || cyc == 130 || cyc == 135 || cyc == 137);
    end
    n_vec++;
    if (qa.size() != 0) begin
      n_err++;
      $display("FAIL ignen_leftover got %0d pending exp 0", qa.size());
    end
    ref_en_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh();
    test_overrun();
    test_reset_mid_init();
    test_ignored_en();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
